// File: rtl/seg_scan_if.sv
// seg_scan_if: display data load port and scanned segment/digit outputs
interface seg_scan_if #(
    parameter int NDIGITS = 8
);
    logic                   load;
    logic [4*NDIGITS-1:0]   value;
    logic [NDIGITS-1:0]     dp_in;
    logic [NDIGITS-1:0]     en_in;
    logic                   hex_mode;
    logic                   lzb;
    logic [7:0]             seg;
    logic [NDIGITS-1:0]     an;
    logic                   frame_done;

    modport master (
        output load, value, dp_in, en_in, hex_mode, lzb,
        input  seg, an, frame_done
    );

    modport slave (
        input  load, value, dp_in, en_in, hex_mode, lzb,
        output seg, an, frame_done
    );
endinterface

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: multiplexed seven-segment scanner with frame-synchronous double buffering
module seg_scan_driver #(
    parameter int NDIGITS    = 8,
    parameter int SCAN_DIV   = 1000,
    parameter int DEAD_CYC   = 2,
    parameter int ACTIVE_LOW = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    seg_scan_if.slave  bus
);
    localparam int IW   = NDIGITS > 1 ? $clog2(NDIGITS) : 1;
    localparam int CMAX = SCAN_DIV > DEAD_CYC ? SCAN_DIV : DEAD_CYC;
    localparam int CW   = $clog2(CMAX);
    localparam logic [CW-1:0] SLAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DLAST = CW'(DEAD_CYC > 0 ? DEAD_CYC - 1 : 0);
    localparam logic [IW-1:0] ILAST = IW'(NDIGITS - 1);
    localparam logic          AL    = ACTIVE_LOW != 0;
    localparam logic [7:0] GLYPH [16] = '{
        8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
        8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E
    };

    typedef enum logic {SHOW, DEAD} state_t;

    typedef struct packed {
        logic [4*NDIGITS-1:0] value;
        logic [NDIGITS-1:0]   dp;
        logic [NDIGITS-1:0]   en;
        logic                 hex;
        logic                 lzb;
    } disp_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic               wrap;
    disp_t              in_s, pend_q, act_q;
    logic [3:0]         nib;
    logic               zrun;
    logic [NDIGITS-1:0] blank;
    logic               vis;
    logic [7:0]         glyph;
    logic [7:0]         seg_d, seg_q;
    logic [NDIGITS-1:0] an_d, an_q;
    logic               fd_q;

    assign in_s = {bus.value, bus.dp_in, bus.en_in, bus.hex_mode, bus.lzb};

    // Scan sequencing: lit slot, optional dead slot, then next digit; wrap marks the frame commit
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        idx_d   = idx_q;
        wrap    = 1'b0;
        if ((state_q == SHOW && cnt_q == SLAST && DEAD_CYC == 0) ||
            (state_q == DEAD && cnt_q == DLAST)) begin
            cnt_d   = '0;
            state_d = SHOW;
            idx_d   = idx_q == ILAST ? '0 : idx_q + 1'b1;
            wrap    = idx_q == ILAST;
        end else if (state_q == SHOW && cnt_q == SLAST) begin
            cnt_d   = '0;
            state_d = DEAD;
        end
    end

    // Scan state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SHOW;
            cnt_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
        end
    end

    // Pending buffer holds the latest load; active buffer only changes at frame wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
            act_q  <= '0;
        end else begin
            if (bus.load) pend_q <= in_s;
            if (wrap)     act_q  <= bus.load ? in_s : pend_q;
        end
    end

    // Decode the current digit; blanking scans from the most significant digit down
    always_comb begin
        nib  = act_q.value[idx_q*4 +: 4];
        zrun = 1'b1;
        blank = '0;
        for (int i = NDIGITS - 1; i >= 0; i--) begin
            zrun     = zrun & (act_q.value[4*i +: 4] == 4'd0);
            blank[i] = act_q.lzb & zrun & (i != 0);
        end
        glyph = (!act_q.hex && nib > 4'd9) ? 8'h00 : GLYPH[nib];
        vis   = state_q == SHOW && act_q.en[idx_q] && !blank[idx_q];
        seg_d = vis ? glyph | {7'd0, act_q.dp[idx_q]} : 8'h00;
        an_d  = vis ? NDIGITS'(1) << idx_q : '0;
    end

    // Registered outputs with polarity applied last; reset drives the off level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q <= {8{AL}};
            an_q  <= {NDIGITS{AL}};
            fd_q  <= 1'b0;
        end else begin
            seg_q <= AL ? ~seg_d : seg_d;
            an_q  <= AL ? ~an_d : an_d;
            fd_q  <= wrap;
        end
    end

    assign bus.seg        = seg_q;
    assign bus.an         = an_q;
    assign bus.frame_done = fd_q;
endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: three parameter sets against a cycle-position reference model
module tb_seg_scan_driver;
    typedef struct packed {
        logic [15:0] v;
        logic [3:0]  dp;
        logic [3:0]  en;
        logic        hx;
        logic        lz;
    } disp_t;

    localparam int D  [3] = '{1, 1, 0};
    localparam bit AL [3] = '{1'b0, 1'b1, 1'b0};
    localparam logic [7:0] GL [16] = '{
        8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
        8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E
    };

    logic  clk = 1'b0;
    logic  rst_n = 1'b0;
    logic  load = 1'b0;
    disp_t cur = '0;
    disp_t pend = '0;
    disp_t act [3] = '{'0, '0, '0};
    int    t = 0;
    int    total = 0;
    int    bad = 0;

    seg_scan_if #(.NDIGITS(4)) ifa ();
    seg_scan_if #(.NDIGITS(4)) ifb ();
    seg_scan_if #(.NDIGITS(4)) ifc ();

    assign ifa.load = load;  assign ifa.value = cur.v;  assign ifa.dp_in = cur.dp;
    assign ifa.en_in = cur.en;  assign ifa.hex_mode = cur.hx;  assign ifa.lzb = cur.lz;
    assign ifb.load = load;  assign ifb.value = cur.v;  assign ifb.dp_in = cur.dp;
    assign ifb.en_in = cur.en;  assign ifb.hex_mode = cur.hx;  assign ifb.lzb = cur.lz;
    assign ifc.load = load;  assign ifc.value = cur.v;  assign ifc.dp_in = cur.dp;
    assign ifc.en_in = cur.en;  assign ifc.hex_mode = cur.hx;  assign ifc.lzb = cur.lz;

    seg_scan_driver #(.NDIGITS(4), .SCAN_DIV(4), .DEAD_CYC(1), .ACTIVE_LOW(0))
        dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    seg_scan_driver #(.NDIGITS(4), .SCAN_DIV(4), .DEAD_CYC(1), .ACTIVE_LOW(1))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));
    seg_scan_driver #(.NDIGITS(4), .SCAN_DIV(4), .DEAD_CYC(0), .ACTIVE_LOW(0))
        dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc));

    always #5 clk = ~clk;

    function automatic logic [11:0] obs(int k);
        return k == 0 ? {ifa.seg, ifa.an} : k == 1 ? {ifb.seg, ifb.an} : {ifc.seg, ifc.an};
    endfunction

    function automatic logic [11:0] fdo(int k);
        return {11'd0, k == 0 ? ifa.frame_done : k == 1 ? ifb.frame_done : ifc.frame_done};
    endfunction

    function automatic int frm(int k);
        return 4 * (4 + D[k]);
    endfunction

    // Expected {seg, an} for cycle tc of a frame showing data a
    function automatic logic [11:0] model(int k, int tc, disp_t a);
        int per = 4 + D[k];
        int p = tc % frm(k);
        int d = p / per;
        logic [15:0] sh = a.v >> (4 * d);
        logic [7:0] g;
        logic [3:0] one = 4'(1 << d);
        logic vis;
        logic [11:0] r;
        vis = (p % per) < 4 && a.en[d] && !(a.lz && d > 0 && sh == 16'd0);
        g = (!a.hx && sh[3:0] > 4'd9) ? 8'h00 : GL[sh[3:0]];
        r = vis ? {g | {7'd0, a.dp[d]}, one} : 12'h000;
        return AL[k] ? ~r : r;
    endfunction

    task automatic chk(string tag, logic [11:0] got, logic [11:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s t=%0d got=%h exp=%h", tag, t, got, exp);
        end
    endtask

    task automatic step();
        logic [11:0] e [3];
        logic        fd [3];
        for (int k = 0; k < 3; k++) begin
            e[k]  = model(k, t, act[k]);
            fd[k] = ((t + 1) % frm(k)) == 0;
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("out%0d", k), obs(k), e[k]);
            chk($sformatf("fd%0d", k), fdo(k), {11'd0, fd[k]});
        end
        if (load) pend = cur;
        for (int k = 0; k < 3; k++) if (fd[k]) act[k] = pend;
        t++;
    endtask

    task automatic run(int n);
        repeat (n) step();
    endtask

    task automatic align(int r);
        for (int i = 0; i < 40 && t % 20 != r; i++) step();
    endtask

    task automatic do_load(disp_t d);
        cur = d;
        load = 1'b1;
        step();
        load = 1'b0;
    endtask

    task automatic off_chk();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("off%0d", k), obs(k), AL[k] ? 12'hFFF : 12'h000);
            chk($sformatf("fdrst%0d", k), fdo(k), 12'h000);
        end
    endtask

    task automatic model_reset();
        t = 0;
        pend = '0;
        for (int k = 0; k < 3; k++) act[k] = '0;
    endtask

    initial begin
        repeat (3) begin
            @(posedge clk);
            #1;
            off_chk();
        end
        rst_n = 1'b1;
        model_reset();
        run(45);

        do_load('{v: 16'h4321, dp: 4'b0010, en: 4'hF, hx: 1'b0, lz: 1'b0});
        run(25);
        align(1);
        chk("dec_d0_a", {ifa.seg, ifa.an}, {8'h60, 4'b0001});
        chk("dec_d0_b", {ifb.seg, ifb.an}, {8'h9F, 4'b1110});
        run(4);
        chk("dead_a", {ifa.seg, ifa.an}, 12'h000);
        chk("dead_b", {ifb.seg, ifb.an}, 12'hFFF);
        run(1);
        chk("dec_d1_a", {ifa.seg, ifa.an}, {8'hDB, 4'b0010});
        run(20);

        do_load('{v: 16'h00AF, dp: 4'b0000, en: 4'hF, hx: 1'b1, lz: 1'b0});
        run(25);
        align(1);
        chk("hex_d0", {ifa.seg, ifa.an}, {8'h8E, 4'b0001});
        run(5);
        chk("hex_d1", {ifa.seg, ifa.an}, {8'hEE, 4'b0010});
        do_load('{v: 16'h00AF, dp: 4'b0000, en: 4'hF, hx: 1'b0, lz: 1'b0});
        run(45);
        do_load('{v: 16'h00AF, dp: 4'b0001, en: 4'hF, hx: 1'b0, lz: 1'b0});
        run(45);

        do_load('{v: 16'h0050, dp: 4'b0000, en: 4'hF, hx: 1'b0, lz: 1'b1});
        run(45);
        do_load('{v: 16'h0000, dp: 4'b1111, en: 4'hF, hx: 1'b0, lz: 1'b1});
        run(45);

        align(7);
        do_load('{v: 16'h1234, dp: 4'b0100, en: 4'hF, hx: 1'b0, lz: 1'b0});
        run(40);
        align(19);
        do_load('{v: 16'h8888, dp: 4'b0000, en: 4'hF, hx: 1'b0, lz: 1'b0});
        run(1);
        chk("coinc_d0", {ifa.seg, ifa.an}, {8'hFE, 4'b0001});
        run(20);

        align(11);
        rst_n = 1'b0;
        #1;
        off_chk();
        model_reset();
        repeat (2) begin
            @(posedge clk);
            #1;
            off_chk();
        end
        rst_n = 1'b1;
        run(45);

        repeat (400) begin
            cur = disp_t'(26'($urandom));
            load = ($urandom % 8) == 0;
            step();
            load = 1'b0;
        end
        run(40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
